gwct_apb_regs: RTL
==================

GWCT_APB_REGS -- requirements
Module: gwct_apb_regs

Interface
REQ-001 SHALL have parameters: FIFO_DEPTH, default 8, mailbox FIFO depth in 32-bit words (power of 2, 2..64); WAIT_CYCLES, default 2, access-phase wait states (0..15).
REQ-002 SHALL have ports: clk  in  1  single clock for all logic.
REQ-003 rstn  in  1  asynchronous active-low reset.
REQ-004 PADDR  in  32  byte address; only [7:0] decoded.
REQ-005 PSEL, PENABLE, PWRITE  in  1 each  APB3/4 control.
REQ-006 PWDATA  in  32  write data.
REQ-007 PSTRB  in  4  byte-lane write strobes.
REQ-008 PPROT  in  3  accepted, ignored.
REQ-009 PRDATA  out  32  read data, valid when PREADY=1.
REQ-010 PREADY  out  1  transfer-complete.
REQ-011 PSLVERR  out  1  error, valid only when PREADY=1.
REQ-012 irq  out  1  level interrupt.

Function
REQ-013 SHALL decode: 0x00 ID (RO, 0x47574354); 0x04 CTRL (RW bit0 irq_en, bit1 fifo_flush self-clearing); 0x08 FIFO data (write pushes, read pops); 0x0C STATUS (RO [6:0] count, [8] empty, [9] full; bit10 overflow and bit11 underflow sticky, write-1-to-clear); 0x10-0x1C SCRATCH0-3 (RW, per-byte PSTRB).
REQ-014 SHALL run FSM IDLE -> SETUP (PSEL & !PENABLE) -> WAIT (WAIT_CYCLES>0) -> ACCESS; ACCESS asserts PREADY exactly one cycle, then returns to IDLE, or to SETUP if a new setup phase is presented.
REQ-015 SHALL perform side effects (register write, push, pop, W1C) exactly once, in the PREADY=1 cycle.
REQ-016 SHALL drive PRDATA only in the PREADY=1 cycle, else 0x00000000.
REQ-017 SHALL complete unmapped or PADDR[1:0]!=0 accesses with PSLVERR=1, PRDATA=0, no side effects.
REQ-018 SHALL complete writes to RO registers (ID, STATUS except bits 10-11) with PSLVERR=0 and no effect.
REQ-019 SHALL treat push when full as dropped data, set overflow, PSLVERR=1.
REQ-020 SHALL return 0 on pop when empty, set underflow, PSLVERR=1.
REQ-021 SHALL ignore PSTRB for FIFO data and CTRL (whole-word) writes.
REQ-022 SHALL use wrap-around read/write pointers of log2(FIFO_DEPTH)+1 bits; count = wptr-rptr modulo.
REQ-023 SHALL let flush clear pointers and count in the cycle after the CTRL write, leaving sticky bits.
REQ-024 SHALL register irq = irq_en & (!empty | overflow), updated one cycle after the causing event.
REQ-025 SHALL abort to IDLE without side effects if PSEL deasserts in SETUP or WAIT (protocol violation tolerance).

Reset
REQ-026 SHALL, on rstn low at any time including mid-transfer, asynchronously set FSM=IDLE, PREADY=0, PSLVERR=0, PRDATA=0, irq=0, CTRL=0, SCRATCH0-3=0, FIFO empty, sticky bits 0.
REQ-027 SHALL accept the first setup phase in the first clk edge after rstn rises.

Configuration
REQ-028 SHALL, with GWCT_APB_WAIT_EN defined, insert WAIT_CYCLES wait states per REQ-014.
REQ-029 SHALL, without GWCT_APB_WAIT_EN, omit WAIT state: PREADY=1 in the first access-phase cycle, WAIT_CYCLES ignored.

Verification
REQ-030 Read 0x00 -> PRDATA=0x47574354, PSLVERR=0, PREADY after WAIT_CYCLES+1 access cycles (1 without macro).
REQ-031 Write 0x10=0xDEADBEEF with PSTRB=0b0101, then read 0x10 -> 0x00AD00EF.
REQ-032 Push 9 words 1..9 (depth 8) -> 9th PSLVERR=1, STATUS=0x608 (count 8, full, overflow); pop 8 -> 1..8 in order, STATUS empty.
REQ-033 irq_en=1, push one word -> irq=1 next cycle; pop it -> irq=0; write 0x0C=0x400 clears overflow.
REQ-034 Read 0x20 and 0x06 -> PSLVERR=1, PRDATA=0, no register changes.
REQ-035 Assert rstn low during WAIT of a FIFO push -> PREADY=0 immediately, FIFO empty, no push after release.

Source files
------------

// File: rtl/gwct_apb_regs.sv
// APB3/4 slave: ID, CTRL, a mailbox FIFO with sticky status, and four byte-strobed scratch words.
// Define GWCT_APB_WAIT_EN to insert WAIT_CYCLES access-phase wait states; without it every access is zero-wait.

module gwct_apb_regs #(
    parameter int FIFO_DEPTH  = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] PADDR,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [31:0] PWDATA,
    input  logic [3:0]  PSTRB,
    input  logic [2:0]  PPROT,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR,
    output logic        irq
);

    localparam int          PW          = $clog2(FIFO_DEPTH);
    localparam logic [31:0] ID_VALUE    = 32'h4757_4354;
    localparam logic [6:0]  DEPTH_CNT   = 7'(FIFO_DEPTH);
    localparam logic [PW:0] PTR_ONE     = 1;
    localparam logic        LP_HAS_WAIT = (WAIT_CYCLES > 0);
`ifdef GWCT_APB_WAIT_EN
    localparam logic [3:0]  LP_WAIT_LOAD = 4'((WAIT_CYCLES > 0) ? (WAIT_CYCLES - 1) : 0);
`endif

    typedef enum logic [1:0] {IDLE, SETUP, WAIT, ACCESS} state_t;

    state_t      r_state;
    state_t      w_phase;
    state_t      w_state_nxt;
    logic [3:0]  r_wcnt;
    logic [3:0]  w_wcnt_nxt;

    logic [PW:0] r_wptr;
    logic [PW:0] r_rptr;
    logic [PW:0] w_diff;
    logic [6:0]  w_count;
    logic        w_empty;
    logic        w_full;
    logic [31:0] r_mem [FIFO_DEPTH];

    logic [31:0] r_scratch [4];
    logic        r_irq_en;
    logic        r_ovf;
    logic        r_udf;
    logic        r_irq;

    logic [7:0]  w_addr;
    logic        w_bad_addr;
    logic        w_xfer;
    logic        w_wr;
    logic        w_rd;
    logic        w_is_fifo;
    logic        w_is_scr;
    logic        w_ctrl_wr;
    logic        w_flush;
    logic        w_sts_wr;
    logic        w_scr_wr;
    logic        w_push;
    logic        w_pop;
    logic        w_ovf_set;
    logic        w_udf_set;
    logic [31:0] w_status;
    logic        w_unused;

    function automatic logic [31:0] f_strb_merge(input logic [31:0] old_v,
                                                 input logic [31:0] new_v,
                                                 input logic [3:0]  strb);
        logic [31:0] res;
        res = old_v;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) res[8*b +: 8] = new_v[8*b +: 8];
        end
        return res;
    endfunction

    // SETUP is the bus setup-phase cycle, recognised combinationally while the
    // register still reads IDLE, so a zero-wait access completes one cycle later.
    always_comb begin
        w_phase = r_state;
        if (r_state == IDLE && PSEL && !PENABLE) w_phase = SETUP;
        w_state_nxt = w_phase;
        w_wcnt_nxt  = r_wcnt;
        case (w_phase)
            IDLE: w_state_nxt = IDLE;
            SETUP: begin
`ifdef GWCT_APB_WAIT_EN
                if (LP_HAS_WAIT) begin
                    w_state_nxt = WAIT;
                    w_wcnt_nxt  = LP_WAIT_LOAD;
                end else begin
                    w_state_nxt = ACCESS;
                end
`else
                w_state_nxt = ACCESS;
`endif
            end
            WAIT: begin
                if (!PSEL) begin
                    w_state_nxt = IDLE;
                end else if (r_wcnt == 4'd0) begin
                    w_state_nxt = ACCESS;
                end else begin
                    w_state_nxt = WAIT;
                    w_wcnt_nxt  = r_wcnt - 4'd1;
                end
            end
            ACCESS:  w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= IDLE;
            r_wcnt  <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_wcnt  <= w_wcnt_nxt;
        end
    end

    assign w_diff  = r_wptr - r_rptr;
    assign w_count = 7'(w_diff);
    assign w_empty = (w_count == 7'd0);
    assign w_full  = (w_count == DEPTH_CNT);

    // All side effects are qualified by ACCESS, which is exactly the PREADY=1 cycle.
    assign w_addr     = PADDR[7:0];
    assign w_bad_addr = (w_addr[1:0] != 2'b00) || (w_addr > 8'h1C);
    assign w_xfer     = (r_state == ACCESS);
    assign w_wr       = w_xfer && !w_bad_addr && PWRITE;
    assign w_rd       = w_xfer && !w_bad_addr && !PWRITE;
    assign w_is_fifo  = (w_addr == 8'h08);
    assign w_is_scr   = (w_addr[7:4] == 4'h1);
    assign w_ctrl_wr  = w_wr && (w_addr == 8'h04);
    assign w_flush    = w_ctrl_wr && PWDATA[1];
    assign w_sts_wr   = w_wr && (w_addr == 8'h0C);
    assign w_scr_wr   = w_wr && w_is_scr;
    assign w_push     = w_wr && w_is_fifo && !w_full;
    assign w_ovf_set  = w_wr && w_is_fifo && w_full;
    assign w_pop      = w_rd && w_is_fifo && !w_empty;
    assign w_udf_set  = w_rd && w_is_fifo && w_empty;

    assign w_status = {20'd0, r_udf, r_ovf, w_full, w_empty, 1'b0, w_count};

    always_comb begin
        PRDATA = 32'd0;
        if (w_rd) begin
            case (w_addr)
                8'h00:   PRDATA = ID_VALUE;
                8'h04:   PRDATA = {31'd0, r_irq_en};
                8'h08:   PRDATA = w_pop ? r_mem[r_rptr[PW-1:0]] : 32'd0;
                8'h0C:   PRDATA = w_status;
                default: PRDATA = w_is_scr ? r_scratch[w_addr[3:2]] : 32'd0;
            endcase
        end
    end

    assign PREADY  = w_xfer;
    assign PSLVERR = w_xfer && (w_bad_addr || w_ovf_set || w_udf_set);
    assign irq     = r_irq;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_irq_en <= 1'b0;
            r_ovf    <= 1'b0;
            r_udf    <= 1'b0;
            r_irq    <= 1'b0;
            for (int i = 0; i < 4; i++) r_scratch[i] <= 32'd0;
        end else begin
            r_irq <= r_irq_en && (!w_empty || r_ovf);
            if (w_ctrl_wr) r_irq_en <= PWDATA[0];
            if (w_flush) begin
                r_wptr <= '0;
                r_rptr <= '0;
            end else begin
                if (w_push) r_wptr <= r_wptr + PTR_ONE;
                if (w_pop)  r_rptr <= r_rptr + PTR_ONE;
            end
            if (w_ovf_set)                  r_ovf <= 1'b1;
            else if (w_sts_wr && PWDATA[10]) r_ovf <= 1'b0;
            if (w_udf_set)                  r_udf <= 1'b1;
            else if (w_sts_wr && PWDATA[11]) r_udf <= 1'b0;
            if (w_scr_wr) r_scratch[w_addr[3:2]] <= f_strb_merge(r_scratch[w_addr[3:2]], PWDATA, PSTRB);
        end
    end

    // FIFO storage carries data only, so it is left out of reset.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr[PW-1:0]] <= PWDATA;
    end

    assign w_unused = ^{PPROT, PADDR[31:8], LP_HAS_WAIT};

endmodule
